// File: rtl/alu_pkg.sv
// Shared ALU-side types: the architectural flags layout and a select range helper
// used by the bus register file.
package alu_pkg;

   localparam int FLAGS_W = 4;

   typedef struct packed {
      logic ovf;
      logic carry;
      logic pos;
      logic zero;
   } alu_flags_t;

   // True when a register select addresses an implemented register.
   function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_regs);
      return sel < num_regs;
   endfunction

endpackage

// File: rtl/tristate_driver.sv
// Drives a value onto a shared tri-state bus while oe is high, releases it otherwise.
module tristate_driver #(
   parameter int DATA_W = 8
) (
   input  logic              oe,
   input  logic [DATA_W-1:0] data,
   inout  wire  [DATA_W-1:0] bus
);

   assign bus = oe ? data : {DATA_W{1'bz}};

endmodule

// File: rtl/bus_register_file.sv
// Register file on the receiving end of the tri-state ALU result bus: captures results,
// feeds ALU operands, drives registers back onto the bus, holds flags and a sticky fault bit.
module bus_register_file
   import alu_pkg::*;
#(
   parameter  int DATA_W    = 8,
   parameter  int NUM_REGS  = 4,
   localparam int REG_SEL_W = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   inout  wire  [DATA_W-1:0]    data_bus,
   input  logic                 load_en,
   input  logic [REG_SEL_W-1:0] load_sel,
   input  logic [REG_SEL_W-1:0] a_sel,
   input  logic [REG_SEL_W-1:0] b_sel,
   output logic [DATA_W-1:0]    operand_a,
   output logic [DATA_W-1:0]    operand_b,
   input  logic                 bus_oe,
   input  logic [REG_SEL_W-1:0] bus_sel,
   input  logic [FLAGS_W-1:0]   flags_in,
   input  logic                 flags_load,
   output logic [FLAGS_W-1:0]   flags,
   output logic                 bus_fault,
   input  logic                 fault_clr
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   alu_flags_t        flags_q;

   logic              load_sel_ok;
   logic              bus_sel_ok;
   logic              fault_now;
   logic              write_en;
   logic              drive_en;
   logic [DATA_W-1:0] drive_data;

   assign load_sel_ok = sel_in_range(32'(load_sel), NUM_REGS);
   assign bus_sel_ok  = sel_in_range(32'(bus_sel), NUM_REGS);

   // A load while we drive the bus would capture our own output, so it counts as a fault.
   assign fault_now = (load_en & bus_oe)
                    | (load_en & ~load_sel_ok)
                    | (bus_oe  & ~bus_sel_ok);
   assign write_en  = load_en & ~fault_now;

   // The bus is released while in reset even if bus_oe is held high.
   assign drive_en  = bus_oe & bus_sel_ok & rst_n;

   always_comb begin
      operand_a  = '0;
      operand_b  = '0;
      drive_data = '0;
      if (sel_in_range(32'(a_sel), NUM_REGS))
         operand_a = regs[a_sel];
      if (sel_in_range(32'(b_sel), NUM_REGS))
         operand_b = regs[b_sel];
      if (bus_sel_ok)
         drive_data = regs[bus_sel];
   end

   tristate_driver #(.DATA_W(DATA_W)) u_bus_drv (
      .oe   (drive_en),
      .data (drive_data),
      .bus  (data_bus)
   );

   // NOTE: the register array is reset because operands must read 0 out of reset;
   // a RAM-style array without reset would leave them undefined.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (write_en) begin
         regs[load_sel] <= data_bus;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q   <= '0;
         bus_fault <= 1'b0;
      end else begin
         if (flags_load)
            flags_q <= alu_flags_t'(flags_in);
         // Setting has priority so a fault in the clearing cycle is not lost.
         if (fault_now)
            bus_fault <= 1'b1;
         else if (fault_clr)
            bus_fault <= 1'b0;
      end
   end

   assign flags = flags_q;

endmodule

// File: tb/tb_bus_register_file.sv
// Scoreboard bench for bus_register_file: a 4-register instance for the main function and
// a 3-register instance for out-of-range selects. Expectations queue up; a monitor checks them.
module tb_bus_register_file;

   typedef enum logic [3:0] {
      K_OPA, K_OPB, K_BUS, K_FLAGS, K_FAULT, K_OPA3, K_OPB3, K_BUS3, K_FAULT3
   } kind_e;

   typedef struct packed {
      kind_e       kind;
      logic [7:0]  val;
      logic [15:0] tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 4-register instance
   wire  [7:0] data_bus;
   logic [7:0] ext_data;
   logic       ext_oe;
   logic       load_en, bus_oe, flags_load, fault_clr;
   logic [1:0] load_sel, a_sel, b_sel, bus_sel;
   logic [3:0] flags_in, flags;
   logic [7:0] operand_a, operand_b;
   logic       bus_fault;
   assign data_bus = ext_oe ? ext_data : 8'hzz;

   // 3-register instance
   wire  [7:0] data_bus3;
   logic [7:0] ext3_data;
   logic       ext3_oe;
   logic       load_en3, bus_oe3, flags_load3, fault_clr3;
   logic [1:0] load_sel3, a_sel3, b_sel3, bus_sel3;
   logic [3:0] flags_in3, flags3;
   logic [7:0] operand_a3, operand_b3;
   logic       bus_fault3;
   assign data_bus3 = ext3_oe ? ext3_data : 8'hzz;

   bus_register_file #(.DATA_W(8), .NUM_REGS(4)) dut (
      .clk(clk), .rst_n(rst_n), .data_bus(data_bus),
      .load_en(load_en), .load_sel(load_sel), .a_sel(a_sel), .b_sel(b_sel),
      .operand_a(operand_a), .operand_b(operand_b),
      .bus_oe(bus_oe), .bus_sel(bus_sel),
      .flags_in(flags_in), .flags_load(flags_load), .flags(flags),
      .bus_fault(bus_fault), .fault_clr(fault_clr)
   );

   bus_register_file #(.DATA_W(8), .NUM_REGS(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .data_bus(data_bus3),
      .load_en(load_en3), .load_sel(load_sel3), .a_sel(a_sel3), .b_sel(b_sel3),
      .operand_a(operand_a3), .operand_b(operand_b3),
      .bus_oe(bus_oe3), .bus_sel(bus_sel3),
      .flags_in(flags_in3), .flags_load(flags_load3), .flags(flags3),
      .bus_fault(bus_fault3), .fault_clr(fault_clr3)
   );

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   step_no  = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp_v);
   endtask

   task automatic expect_val(input kind_e k, input logic [7:0] v);
      exp_t e;
      e.kind = k;
      e.val  = v;
      e.tag  = 16'(step_no);
      exp_q.push_back(e);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      step_no++;
   endtask

   // Monitor: outputs are sampled on the falling edge, away from the capturing edge.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t       e;
         logic [7:0] act;
         e = exp_q.pop_front();
         case (e.kind)
            K_OPA:    act = operand_a;
            K_OPB:    act = operand_b;
            K_BUS:    act = data_bus;
            K_FLAGS:  act = {4'b0, flags};
            K_FAULT:  act = {7'b0, bus_fault};
            K_OPA3:   act = operand_a3;
            K_OPB3:   act = operand_b3;
            K_BUS3:   act = data_bus3;
            K_FAULT3: act = {7'b0, bus_fault3};
            default:  act = 8'hxx;
         endcase
         check($sformatf("%s@step%0d", e.kind.name(), e.tag), act, e.val);
      end
   end

   initial begin
      rst_n = 1'b0;
      ext_data = '0;  ext_oe = 1'b0;
      load_en = 1'b0; bus_oe = 1'b0; flags_load = 1'b0; fault_clr = 1'b0;
      load_sel = '0;  a_sel = '0; b_sel = '0; bus_sel = '0; flags_in = '0;
      ext3_data = '0; ext3_oe = 1'b0;
      load_en3 = 1'b0; bus_oe3 = 1'b0; flags_load3 = 1'b0; fault_clr3 = 1'b0;
      load_sel3 = '0; a_sel3 = '0; b_sel3 = '0; bus_sel3 = '0; flags_in3 = '0;

      // Reset state; a probe value on the bus must come through unopposed.
      cycle();
      ext_oe = 1'b1; ext_data = 8'hC3;
      expect_val(K_OPA, 8'h00); expect_val(K_OPB, 8'h00);
      expect_val(K_FLAGS, 8'h00); expect_val(K_FAULT, 8'h00); expect_val(K_BUS, 8'hC3);

      // Load regs[1]=3C, then regs[2]=A5 with 1-cycle visibility.
      cycle();
      rst_n = 1'b1; ext_data = 8'h3C; load_en = 1'b1; load_sel = 2'd1;
      cycle();
      ext_data = 8'hA5; load_sel = 2'd2; a_sel = 2'd2; b_sel = 2'd1;
      expect_val(K_OPA, 8'h00); expect_val(K_OPB, 8'h3C);
      cycle();
      ext_oe = 1'b0; load_en = 1'b0;
      expect_val(K_OPA, 8'hA5);

      // Drive regs[1] onto the bus, then release it.
      bus_oe = 1'b1; bus_sel = 2'd1;
      expect_val(K_BUS, 8'h3C);
      cycle();
      bus_oe = 1'b0; ext_oe = 1'b1; ext_data = 8'hC3;
      expect_val(K_BUS, 8'hC3); expect_val(K_FAULT, 8'h00);

      // Self-loop: regs[0]=11, then load_en with bus_oe driving regs[1].
      cycle();
      ext_data = 8'h11; load_sel = 2'd0; load_en = 1'b1;
      cycle();
      ext_oe = 1'b0; bus_oe = 1'b1; bus_sel = 2'd1; a_sel = 2'd0;
      expect_val(K_OPA, 8'h11); expect_val(K_BUS, 8'h3C); expect_val(K_FAULT, 8'h00);
      cycle();
      load_en = 1'b0; bus_oe = 1'b0; fault_clr = 1'b1;
      expect_val(K_OPA, 8'h11); expect_val(K_FAULT, 8'h01);
      cycle();
      fault_clr = 1'b0;
      expect_val(K_FAULT, 8'h00);

      // Fault and clear in the same cycle: set wins.
      cycle();
      load_en = 1'b1; bus_oe = 1'b1; fault_clr = 1'b1;
      cycle();
      load_en = 1'b0; bus_oe = 1'b0;
      expect_val(K_FAULT, 8'h01); expect_val(K_OPA, 8'h11);
      cycle();
      fault_clr = 1'b0;
      expect_val(K_FAULT, 8'h00);

      // Flags and register load on the same edge, then hold, then reload.
      cycle();
      ext_oe = 1'b1; ext_data = 8'h5E; load_sel = 2'd3; load_en = 1'b1;
      flags_in = 4'b1010; flags_load = 1'b1; a_sel = 2'd3;
      expect_val(K_OPA, 8'h00); expect_val(K_FLAGS, 8'h00);
      cycle();
      ext_oe = 1'b0; load_en = 1'b0; flags_in = 4'b0101; flags_load = 1'b0; b_sel = 2'd3;
      expect_val(K_OPA, 8'h5E); expect_val(K_OPB, 8'h5E); expect_val(K_FLAGS, 8'h0A);
      cycle();
      flags_load = 1'b1;
      expect_val(K_FLAGS, 8'h0A);
      cycle();
      flags_load = 1'b0;
      expect_val(K_FLAGS, 8'h05);

      // Mid-run reset with a fault set, bus driven and a flags load pending.
      cycle();
      load_en = 1'b1; bus_oe = 1'b1; bus_sel = 2'd1; load_sel = 2'd0;
      cycle();
      load_en = 1'b0; flags_in = 4'b1111; flags_load = 1'b1; a_sel = 2'd3; b_sel = 2'd1;
      expect_val(K_FAULT, 8'h01); expect_val(K_OPA, 8'h5E);
      expect_val(K_BUS, 8'h3C); expect_val(K_FLAGS, 8'h05);
      cycle();
      rst_n = 1'b0; ext_oe = 1'b1; ext_data = 8'hC3;
      expect_val(K_OPA, 8'h00); expect_val(K_OPB, 8'h00); expect_val(K_FLAGS, 8'h00);
      expect_val(K_FAULT, 8'h00); expect_val(K_BUS, 8'hC3);
      cycle();
      rst_n = 1'b1; flags_load = 1'b0; bus_oe = 1'b0; ext_oe = 1'b0;
      expect_val(K_FLAGS, 8'h00); expect_val(K_FAULT, 8'h00); expect_val(K_OPA, 8'h00);

      // NUM_REGS=3: out-of-range load and drive.
      cycle();
      ext3_oe = 1'b1; ext3_data = 8'h77; load_en3 = 1'b1; load_sel3 = 2'd2;
      cycle();
      ext3_data = 8'h99; load_sel3 = 2'd3; a_sel3 = 2'd3; b_sel3 = 2'd2;
      expect_val(K_OPB3, 8'h77); expect_val(K_FAULT3, 8'h00); expect_val(K_OPA3, 8'h00);
      cycle();
      ext3_oe = 1'b0; load_en3 = 1'b0; fault_clr3 = 1'b1;
      expect_val(K_FAULT3, 8'h01); expect_val(K_OPA3, 8'h00); expect_val(K_OPB3, 8'h77);
      cycle();
      fault_clr3 = 1'b0; bus_oe3 = 1'b1; bus_sel3 = 2'd3; ext3_oe = 1'b1; ext3_data = 8'h3C;
      expect_val(K_FAULT3, 8'h00); expect_val(K_BUS3, 8'h3C);
      cycle();
      bus_oe3 = 1'b0; ext3_oe = 1'b0;
      expect_val(K_FAULT3, 8'h01);
      cycle();
      bus_oe3 = 1'b1; bus_sel3 = 2'd2;
      expect_val(K_BUS3, 8'h77);
      cycle();
      bus_oe3 = 1'b0;

      // Let the monitor drain, bounded.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
